mergesort_main: RTL and testbench

// - HLS-style top of a 32-element merge-sort kernel, run-to-completion on a start pulse.
// - On start: fills a private 32-byte array with a fixed seed pattern, then sorts it ascending
//   (signed 8-bit) by bottom-up merge sort through a 32-byte temp buffer, then pulses done.
// - A 2-channel slave RAM port lets the testbench or host read back results and preload data.

---
 rtl/mergesort_main.sv | 184 ++++++++++++++++++
 tb/tb_mergesort_main.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mergesort_main.sv
// mergesort_main: run-to-completion 32-element signed merge-sort kernel.
// On start it seeds a private 32-byte array, then sorts it ascending by
// bottom-up merge sort through a 32-byte temp buffer, and pulses done_port.
// A 2-channel slave RAM port reads/writes both regions while the kernel is idle.
// Optional feature macro: MERGESORT_SKIP_INIT_EN (drop INIT, sort preloaded data).
// Slave handshake: an access is accepted in the cycle oe|we is high on a
// channel; Sout_DataRdy for that channel is high exactly one cycle later,
// carrying the read data for reads.
module mergesort_main #(
  parameter int MEM_var_28859_28863 = 64,
  parameter int MEM_var_28861_28867 = 32,
  parameter int MEM_var_29012_28863 = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start_port,
  input  logic [1:0]  S_oe_ram,
  input  logic [1:0]  S_we_ram,
  input  logic [13:0] S_addr_ram,
  input  logic [15:0] S_Wdata_ram,
  input  logic [7:0]  S_data_ram_size,
  output logic        done_port,
  output logic [15:0] Sout_Rdata_ram,
  output logic [1:0]  Sout_DataRdy,
  output logic [2:0]  state_dbg
);

  localparam int ARR_BASE = MEM_var_28859_28863;
  localparam int TMP_BASE = MEM_var_28861_28867;

  if (MEM_var_29012_28863 != MEM_var_28861_28867) begin : g_bad_tmp_view
    $error("merge view of temp buffer must equal temp buffer base");
  end
  if (!((ARR_BASE + 32 <= TMP_BASE) || (TMP_BASE + 32 <= ARR_BASE)) ||
      (ARR_BASE + 32 > 128) || (TMP_BASE + 32 > 128)) begin : g_bad_regions
    $error("array and temp regions must not overlap and must lie below 128");
  end

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_MERGE, S_COPY, S_DONE} state_t;

  state_t      state, state_nxt;
  logic [4:0]  idx;
  logic [2:0]  pass;
  logic [5:0]  li, ri;
  logic [7:0]  arr [32];
  logic [7:0]  tmp [32];

  // Only byte accesses exist, so the size field carries no information.
  logic unused_size;
  assign unused_size = ^S_data_ram_size;

  // Merge datapath: left run [blk, blk+w), right run [blk+w, blk+2w).
  logic [5:0] w, mask, idx6, left_end, right_end, li_eff, ri_eff;
  logic       blk_start, take_left;
  logic [7:0] merge_val, init_val;

  // Per-output-slot merge selection; run pointers restart at each block.
  always_comb begin
    w         = 6'd1 << pass;
    mask      = (w << 1) - 6'd1;
    idx6      = {1'b0, idx};
    blk_start = (idx6 & mask) == 6'd0;
    left_end  = (idx6 & ~mask) + w;
    right_end = left_end + w;
    li_eff    = blk_start ? idx6 : li;
    ri_eff    = blk_start ? idx6 + w : ri;
    // Equal keys favour the left run, keeping the sort stable.
    take_left = (li_eff < left_end) &&
                ((ri_eff >= right_end) ||
                 ($signed(arr[li_eff[4:0]]) <= $signed(arr[ri_eff[4:0]])));
    merge_val = take_left ? arr[li_eff[4:0]] : arr[ri_eff[4:0]];
    init_val  = 8'd42 + 8'({3'b000, idx} * 8'd37);
  end

  // Slave address decode and combinational read value per channel.
  logic [6:0] ch_addr [2];
  logic       in_arr  [2];
  logic       in_tmp  [2];
  logic [4:0] off_arr [2];
  logic [4:0] off_tmp [2];
  logic [7:0] rd_val  [2];

  // Region hit, offset and read data; the kernel owns RAM outside IDLE.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      ch_addr[k] = S_addr_ram[7*k +: 7];
      in_arr[k]  = (int'(ch_addr[k]) >= ARR_BASE) && (int'(ch_addr[k]) < ARR_BASE + 32);
      in_tmp[k]  = (int'(ch_addr[k]) >= TMP_BASE) && (int'(ch_addr[k]) < TMP_BASE + 32);
      off_arr[k] = 5'(int'(ch_addr[k]) - ARR_BASE);
      off_tmp[k] = 5'(int'(ch_addr[k]) - TMP_BASE);
      rd_val[k]  = 8'd0;
      if (state == S_IDLE) begin
        if (in_arr[k])      rd_val[k] = arr[off_arr[k]];
        else if (in_tmp[k]) rd_val[k] = tmp[off_tmp[k]];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic and done pulse.
  always_comb begin
    state_nxt = state;
    done_port = 1'b0;
    case (state)
      S_IDLE: begin
`ifdef MERGESORT_SKIP_INIT_EN
        if (start_port) state_nxt = S_MERGE;
`else
        if (start_port) state_nxt = S_INIT;
`endif
      end
`ifndef MERGESORT_SKIP_INIT_EN
      S_INIT:  if (idx == 5'd31) state_nxt = S_MERGE;
`endif
      S_MERGE: if (idx == 5'd31) state_nxt = S_COPY;
      S_COPY:  if (idx == 5'd31) state_nxt = (pass == 3'd4) ? S_DONE : S_MERGE;
      S_DONE: begin
        done_port = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign state_dbg = state;

  // Element counter, pass counter and merge run pointers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx  <= 5'd0;
      pass <= 3'd0;
      li   <= 6'd0;
      ri   <= 6'd0;
    end else begin
      if (state == S_INIT || state == S_MERGE || state == S_COPY) idx <= idx + 5'd1;
      else idx <= 5'd0;
      if (state == S_IDLE) pass <= 3'd0;
      else if (state == S_COPY && idx == 5'd31) pass <= pass + 3'd1;
      if (state == S_MERGE) begin
        li <= take_left ? li_eff + 6'd1 : li_eff;
        ri <= take_left ? ri_eff : ri_eff + 6'd1;
      end
    end
  end

  // Storage: kernel writes while busy; slave writes (channel 1 last) while idle.
  always_ff @(posedge clock) begin
    case (state)
`ifndef MERGESORT_SKIP_INIT_EN
      S_INIT:  arr[idx] <= init_val;
`endif
      S_MERGE: tmp[idx] <= merge_val;
      S_COPY:  arr[idx] <= tmp[idx];
      S_IDLE: begin
        for (int k = 0; k < 2; k++) begin
          if (S_we_ram[k]) begin
            if (in_arr[k])      arr[off_arr[k]] <= S_Wdata_ram[8*k +: 8];
            else if (in_tmp[k]) tmp[off_tmp[k]] <= S_Wdata_ram[8*k +: 8];
          end
        end
      end
      default: ;
    endcase
  end

  // Registered slave response; read data holds until the next read.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      Sout_DataRdy   <= 2'b00;
      Sout_Rdata_ram <= 16'd0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        Sout_DataRdy[k] <= S_oe_ram[k] | S_we_ram[k];
        if (S_oe_ram[k]) Sout_Rdata_ram[8*k +: 8] <= rd_val[k];
      end
    end
  end

endmodule

// File: tb/tb_mergesort_main.sv
// tb_mergesort_main: directed bench for mergesort_main with a read scoreboard.
// Honours MERGESORT_SKIP_INIT_EN to select latency and expected sorted data.
module tb_mergesort_main;

  logic        clock = 1'b0;
  logic        reset;
  logic        start_port;
  logic [1:0]  S_oe_ram;
  logic [1:0]  S_we_ram;
  logic [13:0] S_addr_ram;
  logic [15:0] S_Wdata_ram;
  logic [7:0]  S_data_ram_size;
  logic        done_port;
  logic [15:0] Sout_Rdata_ram;
  logic [1:0]  Sout_DataRdy;
  logic [2:0]  state_dbg;

`ifdef MERGESORT_SKIP_INIT_EN
  localparam int LAT = 321;
  localparam logic [7:0] HAND_MIN = 8'd0;
  localparam logic [7:0] HAND_MAX = 8'd31;
`else
  localparam int LAT = 353;
  localparam logic [7:0] HAND_MIN = 8'h80;
  localparam logic [7:0] HAND_MAX = 8'h7D;
`endif

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q0[$];
  logic [8:0] exp_q1[$];
  logic [8:0] mon_e0, mon_e1;
  logic [7:0] gold [32];

  mergesort_main dut (
    .clock(clock), .reset(reset), .start_port(start_port),
    .S_oe_ram(S_oe_ram), .S_we_ram(S_we_ram), .S_addr_ram(S_addr_ram),
    .S_Wdata_ram(S_Wdata_ram), .S_data_ram_size(S_data_ram_size),
    .done_port(done_port), .Sout_Rdata_ram(Sout_Rdata_ram),
    .Sout_DataRdy(Sout_DataRdy), .state_dbg(state_dbg)
  );

  // Clock.
  always #5 clock = ~clock;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Monitor: pop one expectation per acknowledge; bit 8 marks a read to compare.
  always @(negedge clock) begin
    if (!reset) begin
      if (Sout_DataRdy[0]) begin
        if (exp_q0.size() == 0) check("ack0_unexpected", 1, 0);
        else begin
          mon_e0 = exp_q0.pop_front();
          if (mon_e0[8]) check("rd_ch0", int'(Sout_Rdata_ram[7:0]), int'(mon_e0[7:0]));
        end
      end
      if (Sout_DataRdy[1]) begin
        if (exp_q1.size() == 0) check("ack1_unexpected", 1, 0);
        else begin
          mon_e1 = exp_q1.pop_front();
          if (mon_e1[8]) check("rd_ch1", int'(Sout_Rdata_ram[15:8]), int'(mon_e1[7:0]));
        end
      end
    end
  end

  // One-cycle access on either or both channels; expectations pushed at issue.
  task automatic access(input logic [1:0] oe, input logic [1:0] we,
                        input logic [6:0] a0, input logic [6:0] a1,
                        input logic [7:0] w0, input logic [7:0] w1,
                        input logic [7:0] e0, input logic [7:0] e1);
    @(negedge clock);
    S_oe_ram    = oe;
    S_we_ram    = we;
    S_addr_ram  = {a1, a0};
    S_Wdata_ram = {w1, w0};
    if (oe[0] | we[0]) exp_q0.push_back({oe[0], e0});
    if (oe[1] | we[1]) exp_q1.push_back({oe[1], e1});
    @(posedge clock);
    #1;
    S_oe_ram = 2'b00;
    S_we_ram = 2'b00;
  endtask

  task automatic rd(input int ch, input logic [6:0] a, input logic [7:0] e);
    if (ch == 0) access(2'b01, 2'b00, a, 7'd0, 8'd0, 8'd0, e, 8'd0);
    else         access(2'b10, 2'b00, 7'd0, a, 8'd0, 8'd0, 8'd0, e);
  endtask

  task automatic wr(input int ch, input logic [6:0] a, input logic [7:0] d);
    if (ch == 0) access(2'b00, 2'b01, a, 7'd0, d, 8'd0, 8'd0, 8'd0);
    else         access(2'b00, 2'b10, 7'd0, a, 8'd0, d, 8'd0, 8'd0);
  endtask

  task automatic preload();
    for (int i = 0; i < 32; i++) wr(i % 2, 7'(64 + i), 8'(31 - i));
  endtask

  task automatic read_all();
    for (int i = 0; i < 32; i++) rd(0, 7'(64 + i), gold[i]);
  endtask

  task automatic start_pulse();
    @(negedge clock);
    start_port = 1'b1;
    @(posedge clock);
    #1;
    start_port = 1'b0;
  endtask

  // Bounded wait for done, counting cycles after the start edge.
  task automatic wait_done(input string name);
    int cyc;
    cyc = -1;
    for (int c = 1; c <= LAT + 50; c++) begin
      @(negedge clock);
      if (done_port) begin
        cyc = c;
        break;
      end
    end
    check(name, cyc, LAT);
    @(negedge clock);
    check("done_width", int'(done_port), 0);
  endtask

  // Stimulus and final report.
  initial begin
    int seen, n_done, first_c, second_c;
    logic [7:0] t;

`ifdef MERGESORT_SKIP_INIT_EN
    for (int i = 0; i < 32; i++) gold[i] = 8'(i);
`else
    for (int i = 0; i < 32; i++) gold[i] = 8'(42 + 37 * i);
`endif
    for (int i = 1; i < 32; i++) begin
      for (int j = i; j > 0; j--) begin
        if ($signed(gold[j-1]) > $signed(gold[j])) begin
          t = gold[j]; gold[j] = gold[j-1]; gold[j-1] = t;
        end
      end
    end

    reset = 1'b1; start_port = 1'b0;
    S_oe_ram = 2'b00; S_we_ram = 2'b00; S_addr_ram = '0; S_Wdata_ram = '0;
    S_data_ram_size = 8'h88;
    repeat (3) @(negedge clock);
    check("rst_done", int'(done_port), 0);
    check("rst_rdy", int'(Sout_DataRdy), 0);
    check("rst_rdata", int'(Sout_Rdata_ram), 0);
    reset = 1'b0;

    // Run 1: latency, pulse width, sorted contents.
    preload();
    start_pulse();
    wait_done("latency_run1");
    read_all();
    access(2'b11, 2'b00, 7'd64, 7'd95, 8'd0, 8'd0, HAND_MIN, HAND_MAX);

    // Out-of-region reads and dropped writes.
    rd(0, 7'd10, 8'd0);
    rd(1, 7'd100, 8'd0);
    rd(0, 7'd127, 8'd0);
    wr(0, 7'd5, 8'h77);
    rd(1, 7'd5, 8'd0);

    // Temp-region write/read, channel-1 priority, read-before-write.
    wr(0, 7'd40, 8'h5A);
    rd(1, 7'd40, 8'h5A);
    access(2'b00, 2'b11, 7'd41, 7'd41, 8'h11, 8'h22, 8'd0, 8'd0);
    rd(0, 7'd41, 8'h22);
    access(2'b01, 2'b10, 7'd40, 7'd40, 8'd0, 8'h33, 8'h5A, 8'd0);
    rd(0, 7'd40, 8'h33);

    // Reset mid-run: busy reads return 0, no done, then a clean rerun.
    preload();
    start_pulse();
    seen = 0;
    for (int c = 1; c <= 48; c++) begin
      @(negedge clock);
      if (done_port) seen++;
    end
    rd(1, 7'd64, 8'd0);
    wr(0, 7'd70, 8'hEE);
    for (int c = 0; c < 48; c++) begin
      @(negedge clock);
      if (done_port) seen++;
    end
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clock);
      if (done_port) seen++;
    end
    check("no_done_after_reset", seen, 0);
    preload();
    start_pulse();
    wait_done("latency_after_reset");
    read_all();

    // Start held high for 400 cycles: one done per run, back-to-back runs.
    preload();
    @(negedge clock);
    start_port = 1'b1;
    @(posedge clock);
    n_done = 0; first_c = -1; second_c = -1;
    for (int c = 1; c <= 2 * LAT + 40; c++) begin
      @(negedge clock);
      if (done_port) begin
        n_done++;
        if (first_c < 0) first_c = c;
        else if (second_c < 0) second_c = c;
      end
      if (c == 400) start_port = 1'b0;
    end
    check("held_done_count", n_done, 2);
    check("held_first_done", first_c, LAT);
    check("held_second_done", second_c, 2 * LAT + 1);
    read_all();

    repeat (4) @(negedge clock);
    check("q0_drained", exp_q0.size(), 0);
    check("q1_drained", exp_q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
